// File: rtl/pcr_req_arbiter_pkg.sv
// Shared types for the PCR request arbiter: request payload, FSM states, widths.
package pcr_req_arbiter_pkg;

    localparam int unsigned PCR_ADDR_W = 12;
    localparam int unsigned PCR_DATA_W = 64;
    localparam int unsigned PCR_WE_W   = 3;

    typedef struct packed {
        logic [PCR_ADDR_W-1:0] addr;
        logic [PCR_DATA_W-1:0] data;
        logic [PCR_WE_W-1:0]   we;
    } pcr_req_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } pcr_arb_state_t;

endpackage

// File: rtl/pcr_req_arbiter_rr_arb2.sv
// Two-input round-robin grant; rr selects the winner only when both request.
module pcr_rr_arb2 (
    input  logic csr_valid,
    input  logic dbg_valid,
    input  logic rr,
    output logic csr_gnt,
    output logic dbg_gnt
);

    always_comb begin
        csr_gnt = csr_valid && (!dbg_valid || !rr);
        dbg_gnt = dbg_valid && (!csr_valid ||  rr);
    end

endmodule

// File: rtl/pcr_req_arbiter.sv
// Arbitrates the single PCR port between CSR and debug requesters, one transaction
// outstanding, with a watchdog that turns lost responses into error completions.
module pcr_req_arbiter
    import pcr_req_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  core_id_i,

    input  logic                  csr_req_valid_i,
    input  logic [PCR_ADDR_W-1:0] csr_req_addr_i,
    input  logic [PCR_DATA_W-1:0] csr_req_data_i,
    input  logic [PCR_WE_W-1:0]   csr_req_we_i,
    output logic                  csr_req_ready_o,
    output logic                  csr_resp_valid_o,
    output logic [PCR_DATA_W-1:0] csr_resp_data_o,
    output logic                  csr_resp_err_o,

    input  logic                  dbg_req_valid_i,
    input  logic [PCR_ADDR_W-1:0] dbg_req_addr_i,
    input  logic [PCR_DATA_W-1:0] dbg_req_data_i,
    input  logic [PCR_WE_W-1:0]   dbg_req_we_i,
    output logic                  dbg_req_ready_o,
    output logic                  dbg_resp_valid_o,
    output logic [PCR_DATA_W-1:0] dbg_resp_data_o,
    output logic                  dbg_resp_err_o,

    output logic                  pcr_req_valid_o,
    output logic [PCR_ADDR_W-1:0] pcr_req_addr_o,
    output logic [PCR_DATA_W-1:0] pcr_req_data_o,
    output logic [PCR_WE_W-1:0]   pcr_req_we_o,
    output logic                  pcr_req_core_id_o,
    input  logic                  pcr_req_ready_i,
    input  logic                  pcr_resp_valid_i,
    input  logic [PCR_DATA_W-1:0] pcr_resp_data_i,
    input  logic                  pcr_resp_core_id_i,

    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    pcr_arb_state_t        state_q, state_d;
    pcr_req_t              req_q, grant_req;
    logic                  rr_q;
    logic                  owner_q;          // 0 = CSR, 1 = debug
    logic [CNT_W-1:0]      cnt_q;
    logic                  csr_resp_valid_q, dbg_resp_valid_q, resp_err_q;
    logic [PCR_DATA_W-1:0] resp_data_q;

    logic csr_gnt, dbg_gnt, grant, match, timeout, complete;

    pcr_rr_arb2 u_rr_arb (
        .csr_valid (csr_req_valid_i),
        .dbg_valid (dbg_req_valid_i),
        .rr        (rr_q),
        .csr_gnt   (csr_gnt),
        .dbg_gnt   (dbg_gnt)
    );

    always_comb begin
        state_d   = state_q;
        grant     = (state_q == IDLE) && (csr_gnt || dbg_gnt);
        match     = pcr_resp_valid_i && (pcr_resp_core_id_i == core_id_i);
        timeout   = (state_q != IDLE) && (cnt_q == CNT_LAST);
        complete  = timeout || ((state_q == WAIT_RESP) && match);
        grant_req = dbg_gnt ? pcr_req_t'{addr: dbg_req_addr_i, data: dbg_req_data_i, we: dbg_req_we_i}
                            : pcr_req_t'{addr: csr_req_addr_i, data: csr_req_data_i, we: csr_req_we_i};
        unique case (state_q)
            IDLE:      if (grant) state_d = ISSUE;
            ISSUE:     if (timeout) state_d = IDLE;
                       else if (pcr_req_ready_i) state_d = WAIT_RESP;
            WAIT_RESP: if (complete) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q          <= IDLE;
            req_q            <= '0;
            rr_q             <= 1'b0;
            owner_q          <= 1'b0;
            cnt_q            <= '0;
            csr_resp_valid_q <= 1'b0;
            dbg_resp_valid_q <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_data_q      <= '0;
        end else begin
            state_q          <= state_d;
            csr_resp_valid_q <= complete && !owner_q;
            dbg_resp_valid_q <= complete &&  owner_q;
            if (grant) begin
                req_q   <= grant_req;
                owner_q <= dbg_gnt;
                cnt_q   <= '0;
            end else if (state_q != IDLE) begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            // Pointer always moves to the non-owner, so a single active requester
            // never starves the other once it starts requesting.
            if (complete) begin
                resp_data_q <= timeout ? '0 : pcr_resp_data_i;
                resp_err_q  <= timeout;
                rr_q        <= ~owner_q;
            end
        end
    end

    // Ready is gated by reset so it reads 0 while reset is held.
    assign csr_req_ready_o   = rstn_i && (state_q == IDLE) && csr_gnt;
    assign dbg_req_ready_o   = rstn_i && (state_q == IDLE) && dbg_gnt;

    assign csr_resp_valid_o  = csr_resp_valid_q;
    assign csr_resp_data_o   = csr_resp_valid_q ? resp_data_q : '0;
    assign csr_resp_err_o    = csr_resp_valid_q && resp_err_q;
    assign dbg_resp_valid_o  = dbg_resp_valid_q;
    assign dbg_resp_data_o   = dbg_resp_valid_q ? resp_data_q : '0;
    assign dbg_resp_err_o    = dbg_resp_valid_q && resp_err_q;

    assign pcr_req_valid_o   = (state_q == ISSUE) && !timeout;
    assign pcr_req_addr_o    = req_q.addr;
    assign pcr_req_data_o    = req_q.data;
    assign pcr_req_we_o      = req_q.we;
    assign pcr_req_core_id_o = core_id_i;

    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_pcr_req_arbiter.sv
// Directed bench for pcr_req_arbiter: per-cycle vector table plus hand sequences
// for backpressure, timeout and mid-transaction reset.
module tb_pcr_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, core_id;
    logic        csr_valid, csr_ready, csr_rvalid, csr_rerr;
    logic [11:0] csr_addr;
    logic [63:0] csr_data, csr_rdata;
    logic [2:0]  csr_we;
    logic        dbg_valid, dbg_ready, dbg_rvalid, dbg_rerr;
    logic [11:0] dbg_addr;
    logic [63:0] dbg_data, dbg_rdata;
    logic [2:0]  dbg_we;
    logic        pcr_valid, pcr_cid, pcr_ready, pcr_rvalid, pcr_rcid;
    logic [11:0] pcr_addr;
    logic [63:0] pcr_data, pcr_rdata;
    logic [2:0]  pcr_we;
    logic        busy;

    pcr_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .core_id_i(core_id),
        .csr_req_valid_i(csr_valid), .csr_req_addr_i(csr_addr), .csr_req_data_i(csr_data),
        .csr_req_we_i(csr_we), .csr_req_ready_o(csr_ready), .csr_resp_valid_o(csr_rvalid),
        .csr_resp_data_o(csr_rdata), .csr_resp_err_o(csr_rerr),
        .dbg_req_valid_i(dbg_valid), .dbg_req_addr_i(dbg_addr), .dbg_req_data_i(dbg_data),
        .dbg_req_we_i(dbg_we), .dbg_req_ready_o(dbg_ready), .dbg_resp_valid_o(dbg_rvalid),
        .dbg_resp_data_o(dbg_rdata), .dbg_resp_err_o(dbg_rerr),
        .pcr_req_valid_o(pcr_valid), .pcr_req_addr_o(pcr_addr), .pcr_req_data_o(pcr_data),
        .pcr_req_we_o(pcr_we), .pcr_req_core_id_o(pcr_cid), .pcr_req_ready_i(pcr_ready),
        .pcr_resp_valid_i(pcr_rvalid), .pcr_resp_data_i(pcr_rdata), .pcr_resp_core_id_i(pcr_rcid),
        .busy_o(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        cv, dv, prdy, rv, rid;
        logic [63:0] rdata;
        logic        cr, dr, pv, crv, drv, err, bsy;
        logic [11:0] addr;
        logic [63:0] edata;
    } vec_t;

    function automatic vec_t mk(logic cv, logic dv, logic prdy, logic rv, logic rid, logic [63:0] rdata,
                                logic cr, logic dr, logic pv, logic crv, logic drv, logic err,
                                logic bsy, logic [11:0] addr, logic [63:0] edata);
        vec_t v;
        v.cv = cv; v.dv = dv; v.prdy = prdy; v.rv = rv; v.rid = rid; v.rdata = rdata;
        v.cr = cr; v.dr = dr; v.pv = pv; v.crv = crv; v.drv = drv; v.err = err;
        v.bsy = bsy; v.addr = addr; v.edata = edata;
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        rstn = 1'b0; core_id = 1'b0;
        csr_valid = 0; csr_addr = 12'h0C0; csr_data = 64'h1111; csr_we = 3'd0;
        dbg_valid = 0; dbg_addr = 12'h123; dbg_data = 64'h2222; dbg_we = 3'd5;
        pcr_ready = 0; pcr_rvalid = 0; pcr_rdata = '0; pcr_rcid = 0;

        // Simultaneous requests from reset, with CSR re-requesting immediately.
        vq.push_back(mk(1,1,0,0,0,64'h0,        1,0,0,0,0,0,0, 12'h000, 64'h0));
        vq.push_back(mk(1,1,1,0,0,64'h0,        0,0,1,0,0,0,1, 12'h0C0, 64'h0));
        vq.push_back(mk(1,1,0,1,0,64'hA1,       0,0,0,0,0,0,1, 12'h0C0, 64'h0));
        vq.push_back(mk(1,1,0,0,0,64'h0,        0,1,0,1,0,0,0, 12'h0C0, 64'hA1));
        vq.push_back(mk(1,0,1,0,0,64'h0,        0,0,1,0,0,0,1, 12'h123, 64'h0));
        vq.push_back(mk(1,0,0,1,0,64'hB2,       0,0,0,0,0,0,1, 12'h123, 64'h0));
        vq.push_back(mk(1,0,0,0,0,64'h0,        1,0,0,0,1,0,0, 12'h123, 64'hB2));
        vq.push_back(mk(0,0,1,0,0,64'h0,        0,0,1,0,0,0,1, 12'h0C0, 64'h0));
        vq.push_back(mk(0,0,0,1,0,64'hC3,       0,0,0,0,0,0,1, 12'h0C0, 64'h0));
        vq.push_back(mk(0,0,0,0,0,64'h0,        0,0,0,1,0,0,0, 12'h0C0, 64'hC3));
        // Single CSR read: stray in IDLE, stray id in WAIT_RESP, match at N+4.
        vq.push_back(mk(1,0,0,1,0,64'hFF,       1,0,0,0,0,0,0, 12'h0C0, 64'h0));
        vq.push_back(mk(0,0,1,0,0,64'h0,        0,0,1,0,0,0,1, 12'h0C0, 64'h0));
        vq.push_back(mk(0,0,0,0,0,64'h0,        0,0,0,0,0,0,1, 12'h0C0, 64'h0));
        vq.push_back(mk(0,0,0,1,1,64'hBAD,      0,0,0,0,0,0,1, 12'h0C0, 64'h0));
        vq.push_back(mk(0,0,0,1,0,64'hDEADBEEF, 0,0,0,0,0,0,1, 12'h0C0, 64'h0));
        vq.push_back(mk(0,0,0,0,0,64'h0,        0,0,0,1,0,0,0, 12'h0C0, 64'hDEADBEEF));

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pcr_valid", pcr_valid, 0);
        chk("rst_resp_valid", {csr_rvalid, dbg_rvalid, csr_rerr, dbg_rerr}, 0);
        chk("rst_ready", {csr_ready, dbg_ready}, 0);
        chk("rst_payload", {pcr_addr, pcr_data, pcr_we}, 0);
        tick();
        rstn = 1'b1;

        foreach (vq[i]) begin
            csr_valid = vq[i].cv; dbg_valid = vq[i].dv; pcr_ready = vq[i].prdy;
            pcr_rvalid = vq[i].rv; pcr_rcid = vq[i].rid; pcr_rdata = vq[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_csr_ready", i), csr_ready, vq[i].cr);
            chk($sformatf("v%0d_dbg_ready", i), dbg_ready, vq[i].dr);
            chk($sformatf("v%0d_pcr_valid", i), pcr_valid, vq[i].pv);
            chk($sformatf("v%0d_csr_rvalid", i), csr_rvalid, vq[i].crv);
            chk($sformatf("v%0d_dbg_rvalid", i), dbg_rvalid, vq[i].drv);
            chk($sformatf("v%0d_busy", i), busy, vq[i].bsy);
            chk($sformatf("v%0d_pcr_addr", i), pcr_addr, vq[i].addr);
            if (vq[i].crv) begin
                chk($sformatf("v%0d_csr_rdata", i), csr_rdata, vq[i].edata);
                chk($sformatf("v%0d_csr_err", i), csr_rerr, vq[i].err);
            end
            if (vq[i].drv) begin
                chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, vq[i].edata);
                chk($sformatf("v%0d_dbg_err", i), dbg_rerr, vq[i].err);
            end
            tick();
        end
        pcr_rvalid = 0;

        // Backpressure: pointer now favours debug; CSR waits throughout.
        csr_valid = 1; dbg_valid = 1; pcr_ready = 0;
        @(negedge clk);
        chk("bp_dbg_grant", {dbg_ready, csr_ready}, 2'b10);
        tick();
        dbg_valid = 0;
        for (int k = 0; k < 6; k++) begin
            pcr_ready = (k == 5);
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", k), pcr_valid, 1);
            chk($sformatf("bp_hold%0d_payload", k), {pcr_addr, pcr_data, pcr_we}, {12'h123, 64'h2222, 3'd5});
            chk($sformatf("bp_hold%0d_csr_ready", k), csr_ready, 0);
            tick();
        end
        pcr_ready = 0;
        @(negedge clk);
        chk("bp_wait_valid", {pcr_valid, busy, csr_ready}, 3'b010);
        tick();
        pcr_rvalid = 1; pcr_rcid = 0; pcr_rdata = 64'h5555;
        tick();
        pcr_rvalid = 0;
        @(negedge clk);
        chk("bp_dbg_resp", {dbg_rvalid, dbg_rerr, csr_rvalid}, 3'b100);
        chk("bp_dbg_rdata", dbg_rdata, 64'h5555);
        chk("to_csr_grant", csr_ready, 1);

        // Timeout: CSR granted now (cycle G), never answered.
        tick();
        csr_valid = 0; pcr_ready = 1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("to_c%0d_pending", k), {csr_rvalid, busy}, 2'b01);
            chk($sformatf("to_c%0d_pcr_valid", k), pcr_valid, (k == 1));
            tick();
            pcr_ready = 0;
        end
        pcr_rvalid = 1; pcr_rcid = 0; pcr_rdata = 64'h9999;
        @(negedge clk);
        chk("to_resp", {csr_rvalid, csr_rerr, dbg_rvalid, busy}, 4'b1100);
        chk("to_rdata", csr_rdata, 64'h0);
        tick();
        pcr_rvalid = 0;
        @(negedge clk);
        chk("to_late_ignored", {csr_rvalid, dbg_rvalid, busy}, 3'b000);
        tick();

        // Reset in WAIT_RESP, then serve a fresh request with core id 1.
        dbg_valid = 1;
        tick();
        dbg_valid = 0; pcr_ready = 1;
        tick();
        pcr_ready = 0; csr_valid = 1; dbg_valid = 1;
        @(negedge clk);
        chk("mr_in_wait", busy, 1);
        tick();
        #1 rstn = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_pcr", {pcr_valid, pcr_addr, pcr_data, pcr_we}, 0);
        chk("mr_ready", {csr_ready, dbg_ready}, 0);
        chk("mr_resp", {csr_rvalid, dbg_rvalid, csr_rerr, dbg_rerr}, 0);
        tick();
        rstn = 1'b1; csr_valid = 0; dbg_valid = 0;
        pcr_rvalid = 1; pcr_rcid = 0; pcr_rdata = 64'h4444;
        tick();
        pcr_rvalid = 0;
        @(negedge clk);
        chk("mr_no_completion", {csr_rvalid, dbg_rvalid, busy}, 3'b000);
        tick();
        core_id = 1; csr_valid = 1; csr_addr = 12'h0C4; csr_we = 3'd2;
        @(negedge clk);
        chk("mr_new_grant", csr_ready, 1);
        tick();
        csr_valid = 0; pcr_ready = 1;
        @(negedge clk);
        chk("mr_new_issue", {pcr_valid, pcr_cid, pcr_addr, pcr_we}, {1'b1, 1'b1, 12'h0C4, 3'd2});
        tick();
        pcr_ready = 0; pcr_rvalid = 1; pcr_rcid = 1; pcr_rdata = 64'h777;
        tick();
        pcr_rvalid = 0;
        @(negedge clk);
        chk("mr_new_resp", {csr_rvalid, csr_rerr, busy}, 3'b100);
        chk("mr_new_rdata", csr_rdata, 64'h777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pcr_req_arbiter.md
# pcr_req_arbiter

Shares the core's single PCR (performance-counter/config register) port between the CSR unit and the debug-ring register path. It sits between `csr_bsc`/debug logic and the tile's PCR interface. It grants one requester at a time with round-robin fairness and keeps exactly one transaction outstanding. Each response is routed back to its owner, and a watchdog converts lost responses into error completions.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles allowed from issue to response before an error completion.
- `CNT_W`, default `$clog2(TIMEOUT_CYCLES)`: watchdog counter width.

Ports:
- `clk_i` in 1: clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `core_id_i` in 1: this tile's core id; driven onto requests and compared against responses.
- `csr_req_valid_i` in 1: CSR request.
- `csr_req_addr_i` in 12: CSR request address.
- `csr_req_data_i` in 64: CSR write data.
- `csr_req_we_i` in 3: CSR command.
- `csr_req_ready_o` out 1: CSR request accepted this cycle.
- `csr_resp_valid_o` out 1: one-cycle response pulse to CSR.
- `csr_resp_data_o` out 64: response data to CSR.
- `csr_resp_err_o` out 1: CSR completion was a timeout.
- `dbg_req_valid_i`, `dbg_req_addr_i`, `dbg_req_data_i`, `dbg_req_we_i`, `dbg_req_ready_o`, `dbg_resp_valid_o`, `dbg_resp_data_o`, `dbg_resp_err_o`: same widths and meanings as the CSR port, for the debug requester.
- `pcr_req_valid_o` out 1: request to the PCR port.
- `pcr_req_addr_o` out 12: PCR request address.
- `pcr_req_data_o` out 64: PCR write data.
- `pcr_req_we_o` out 3: PCR command.
- `pcr_req_core_id_o` out 1: core id sent with the request.
- `pcr_req_ready_i` in 1: PCR port accepts the request.
- `pcr_resp_valid_i` in 1: PCR response valid.
- `pcr_resp_data_i` in 64: PCR response data.
- `pcr_resp_core_id_i` in 1: core id carried by the response.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_RESP.
- **IDLE:**
  - The grant goes to the requester with valid asserted. If both are valid, the round-robin pointer `rr_q` decides (0 = CSR); `rr_q` resets to 0.
  - The granted requester sees `*_req_ready_o`=1 combinationally in that cycle.
  - The payload and the owner are latched, and the FSM moves to ISSUE.
- **ISSUE:**
  - `pcr_req_valid_o`=1 with the latched payload held stable; `pcr_req_core_id_o`=`core_id_i`.
  - When `pcr_req_ready_i`=1, the FSM moves to WAIT_RESP.
- **WAIT_RESP:**
  - A response matches when `pcr_resp_valid_i`=1 and `pcr_resp_core_id_i`==`core_id_i`.
  - On a match: the owner gets `resp_valid`=1, `resp_data`=`pcr_resp_data_i`, `err`=0. `rr_q` is set to the non-owner and the FSM returns to IDLE.
  - Mismatched-id responses are ignored.
- **Watchdog:**
  - The counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT_RESP.
  - When it reaches `TIMEOUT_CYCLES-1`, the owner gets `resp_valid`=1, `data`=0, `err`=1. `pcr_req_valid_o` drops, `rr_q` flips, and the FSM returns to IDLE.
  - A timeout takes priority over a matching response arriving in the same cycle.
- Every command, reads and writes alike, produces exactly one completion.
- Responses arriving in IDLE or ISSUE (late or stray) are discarded.
- The non-granted requester's ready stays 0; its valid/payload must hold until it is accepted.

## Timing
- **Reset values:** all `*_ready_o`, `*_resp_valid_o`, `*_resp_err_o`, `pcr_req_valid_o` and `busy_o` are 0; all data/addr/we outputs are 0; state is IDLE; counter is 0.
- **Request path:** request accepted in cycle N → `pcr_req_valid_o` high from N+1. With `pcr_req_ready_i` high at N+1, WAIT_RESP begins at N+2.
- **Response path:** matching response in cycle M → owner `resp_valid_o` pulses at M+1 (registered, one cycle). The next grant is possible at M+1 (IDLE at M+1, ready combinational).
- Minimum spacing between back-to-back grants is 3 cycles.
- `resp_data_o` is valid only while `resp_valid_o`=1.
- An asynchronous reset mid-transaction aborts it with no completion; the PCR side must tolerate a dropped valid.

## Structure
- Additions to `drac_pkg`:
  - `pcr_req_t` {addr[11:0], data[63:0], we[2:0]}.
  - `pcr_arb_state_t` enum {IDLE, ISSUE, WAIT_RESP}.
  - `PCR_ADDR_W`=12.
- Sub-module `pcr_rr_arb2`: a 2-input round-robin grant, combinational from valids and `rr_q`. The pointer register stays in the parent.

## Test plan
- **Single CSR read:** CSR read to addr 0x0C0; PCR ready at N+1, response data 0xDEADBEEF at N+4 → `csr_resp_valid_o` at N+5 with 0xDEADBEEF, err=0, dbg outputs idle.
- **Simultaneous requests:** both valid at reset → CSR granted first, debug granted at the cycle after CSR's completion; a second simultaneous pair then grants debug first.
- **Backpressure:** `pcr_req_ready_i` low for 5 cycles → `pcr_req_valid_o` and payload held stable for 6 cycles, no second grant.
- **Timeout:** `TIMEOUT_CYCLES`=16, no response → err completion with data 0 exactly 16 cycles after entering ISSUE. A late response is ignored and `busy_o`=0.
- **Stray response:** a response with `pcr_resp_core_id_i`≠`core_id_i` during WAIT_RESP is ignored; the later matching response completes normally.
- **Reset mid-op:** `rstn_i` asserted in WAIT_RESP → all outputs at reset values immediately; a new request after release is served normally.
